// File: rtl/dmux4_dispatcher.sv
// dmux4_dispatcher: buffered 4-way valid/ready demultiplexer with addressed/rotate steering and per-channel delivery counters
module dmux4_dispatcher #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [1:0]         rr_ptr,
    input  logic [1:0]         cnt_sel,
    output logic [CNT_W-1:0]   cnt_value,
    input  logic               cnt_clr
);
    typedef enum logic {EMPTY, FULL} state_e;

    logic [1:0]            dest;
    logic                  accept;
    logic [3:0]            drain;
    logic [1:0]            rr_q, rr_d;
    logic [3:0][CNT_W-1:0] cnt_all;

    assign dest      = mode ? rr_q : in_sel;
    assign in_ready  = rst_n && (!out_valid[dest] || out_ready[dest]);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid & out_ready;
    assign rr_ptr    = rr_q;
    assign cnt_value = cnt_all[cnt_sel];

    // round-robin pointer steps once per accepted word in rotate mode only
    always_comb rr_d = (accept && mode) ? rr_q + 2'd1 : rr_q;

    // pointer register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rr_q <= '0;
        else        rr_q <= rr_d;

    for (genvar g = 0; g < 4; g++) begin : g_ch
        state_e            st_q, st_d;
        logic [WIDTH-1:0]  data_q, data_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic              load;

        assign load                     = accept && (dest == 2'(g));
        assign out_valid[g]             = (st_q == FULL);
        assign out_data[g*WIDTH +: WIDTH] = data_q;
        assign cnt_all[g]               = cnt_q;

        // holding register: a load wins over a drain so a same-cycle refill leaves no bubble
        always_comb begin
            st_d   = st_q;
            data_d = data_q;
            if (load) begin
                st_d   = FULL;
                data_d = in_data;
            end else if (drain[g]) begin
                st_d = EMPTY;
            end
        end

        // saturating delivery counter; clear dominates a coincident increment
        always_comb cnt_d = cnt_clr ? '0 : (drain[g] && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

        // per-channel state, data and counter registers
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                st_q   <= EMPTY;
                data_q <= '0;
                cnt_q  <= '0;
            end else begin
                st_q   <= st_d;
                data_q <= data_d;
                cnt_q  <= cnt_d;
            end
    end
endmodule
